// File: rtl/echo_delay_ctrl_if.sv
// Single-port synchronous RAM bus between the echo sequencer and its sample buffer.
// rdata returns the word at the address presented on the previous cycle.
interface echo_delay_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/echo_delay_ctrl.sv
// Echo delay-line sequencer: per sample tick, reads the sample written active_delay ticks ago
// from a circular RAM buffer, then writes the new sample. Echo is muted until the buffer is primed.
module echo_delay_ctrl #(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned DATA_W        = 10,
  parameter int unsigned DEFAULT_DELAY = 2048
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [DATA_W-1:0]    sample_in,
  input  logic [ADDR_W-1:0]    delay_len,
  input  logic                 delay_load,
  echo_delay_ctrl_if.master    ram,
  output logic [DATA_W-1:0]    echo_out,
  output logic                 echo_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;

  localparam logic [ADDR_W-1:0] FillMax      = '1;
  localparam logic [ADDR_W-1:0] DefaultDelay = ADDR_W'(DEFAULT_DELAY);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] active_delay_q, active_delay_d;
  logic [ADDR_W-1:0] pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] echo_q, echo_d;
  logic              echo_valid_q, echo_valid_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    fill_d          = fill_q;
    active_delay_d  = active_delay_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    sample_d        = sample_q;
    echo_d          = echo_q;
    echo_valid_d    = 1'b0;
    overrun_d       = overrun_q;

    case (state_q)
      StIdle: begin
        if (tick) begin
          sample_d = sample_in;
          // Delay changes only take effect at a sequence boundary; restart priming.
          if (pending_valid_q) begin
            active_delay_d  = pending_q;
            fill_d          = '0;
            pending_valid_d = 1'b0;
          end
          state_d = StRd;
        end
      end
      StRd: begin
        if (tick) overrun_d = 1'b1;
        state_d = StWr;
      end
      StWr: begin
        if (tick) overrun_d = 1'b1;
        echo_d       = (fill_q >= active_delay_q && active_delay_q != '0) ? ram.rdata : '0;
        echo_valid_d = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        if (fill_q != FillMax) fill_d = fill_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A load coinciding with an accepted tick becomes the next pending value.
    if (delay_load) begin
      pending_d       = delay_len;
      pending_valid_d = 1'b1;
    end
  end

  always_comb begin
    ram.addr  = '0;
    ram.we    = 1'b0;
    ram.wdata = '0;
    case (state_q)
      StRd: ram.addr = wr_ptr_q - active_delay_q;
      StWr: begin
        ram.addr  = wr_ptr_q;
        ram.we    = 1'b1;
        ram.wdata = sample_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      fill_q          <= '0;
      active_delay_q  <= DefaultDelay;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      sample_q        <= '0;
      echo_q          <= '0;
      echo_valid_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      fill_q          <= fill_d;
      active_delay_q  <= active_delay_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      sample_q        <= sample_d;
      echo_q          <= echo_d;
      echo_valid_q    <= echo_valid_d;
      overrun_q       <= overrun_d;
    end
  end

  assign echo_out   = echo_q;
  assign echo_valid = echo_valid_q;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl: random samples and delay loads checked against a sample-history model.
module tb_echo_delay_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 10;
  localparam int unsigned DEF   = 3;
  localparam int          Depth = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          delay_load = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [AW-1:0] delay_len = '0;
  logic [DW-1:0] echo_out;
  logic          echo_valid;
  logic          busy;
  logic          overrun;

  echo_delay_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  echo_delay_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEFAULT_DELAY(DEF)) dut (
    .sysclk    (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .sample_in (sample_in),
    .delay_len (delay_len),
    .delay_load(delay_load),
    .ram       (ram_if),
    .echo_out  (echo_out),
    .echo_valid(echo_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [Depth];
  always @(posedge clk) begin
    if (ram_if.we) mem[ram_if.addr] <= ram_if.wdata;
    ram_if.rdata <= mem[ram_if.addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: echo is the sample accepted `delay` ticks ago, once `delay` ticks
  // have been accepted since the last reset or delay change.
  int            m_delay, m_pend, m_fill, m_wp;
  bit            m_pend_v;
  logic [DW-1:0] hist[$];

  function automatic void model_reset();
    m_delay = DEF; m_pend = 0; m_pend_v = 0; m_fill = 0; m_wp = 0;
    hist.delete();
  endfunction

  function automatic void model_load(input int len);
    m_pend = len; m_pend_v = 1;
  endfunction

  function automatic void model_tick(input logic [DW-1:0] s, input bit ld, input int len,
                                     output logic [DW-1:0] e_echo, output logic [AW-1:0] e_rd,
                                     output logic [AW-1:0] e_wr);
    int n;
    if (m_pend_v) begin
      m_delay = m_pend; m_fill = 0; m_pend_v = 0;
    end
    if (ld) model_load(len);
    e_rd = AW'((m_wp - m_delay + Depth) % Depth);
    e_wr = AW'(m_wp);
    n = hist.size();
    e_echo = (m_delay != 0 && m_fill >= m_delay) ? hist[n - m_delay] : '0;
    hist.push_back(s);
    m_wp = (m_wp + 1) % Depth;
    if (m_fill < Depth - 1) m_fill++;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0; tick = 1'b0; delay_load = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse_load(input logic [AW-1:0] len);
    @(posedge clk); #1; delay_load = 1'b1; delay_len = len;
    @(posedge clk); #1; delay_load = 1'b0;
    model_load(int'(len));
  endtask

  // Issues one tick and records 7 cycles of response:
  // seq = {rd_addr, wr_addr, we(wr,rd), wdata, echo_valid mask, busy mask}
  task automatic do_tick(input logic [DW-1:0] s, input bit ld, input logic [AW-1:0] len,
                         output logic [DW-1:0] o_echo, output logic [33:0] o_seq);
    logic [AW-1:0] rd, wr;
    logic [1:0]    we;
    logic [DW-1:0] wd;
    logic [6:0]    vm, bm;
    rd = '0; wr = '0; we = '0; wd = '0; o_echo = '0;
    @(posedge clk); #1; tick = 1'b1; sample_in = s; delay_load = ld; delay_len = len;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1; tick = 1'b0; delay_load = 1'b0;
      vm[j] = echo_valid;
      bm[j] = busy;
      if (j == 0) begin rd = ram_if.addr; we[0] = ram_if.we; end
      if (j == 1) begin wr = ram_if.addr; we[1] = ram_if.we; wd = ram_if.wdata; end
      if (j == 2) o_echo = echo_out;
    end
    o_seq = {rd, wr, we, wd, vm, bm};
  endtask

  task automatic test_reset();
    logic [DW-1:0] s, e_echo, o_echo;
    logic [AW-1:0] e_rd, e_wr;
    logic [33:0]   o_seq;
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({echo_out, echo_valid, busy, overrun, ram_if.we, ram_if.addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got echo=%h vld=%b busy=%b ovr=%b we=%b addr=%h want all 0",
               echo_out, echo_valid, busy, overrun, ram_if.we, ram_if.addr);
    end
    rst_n = 1'b1;
    model_reset();
    s = DW'($urandom_range(1, 1023));
    model_tick(s, 0, 0, e_echo, e_rd, e_wr);
    do_tick(s, 0, '0, o_echo, o_seq);
    n_tests += 2;
    if (o_seq !== {e_rd, e_wr, 2'b10, s, 7'b0000100, 7'b0000011}) begin
      n_fail++;
      $display("FAIL reset_first_tick_seq: got %h want %h", o_seq,
               {e_rd, e_wr, 2'b10, s, 7'b0000100, 7'b0000011});
    end
    if (o_echo !== e_echo) begin
      n_fail++; $display("FAIL reset_first_echo: got %h want %h", o_echo, e_echo);
    end
  endtask

  task automatic test_basic_echo();
    logic [DW-1:0] s, e_echo, o_echo;
    logic [AW-1:0] e_rd, e_wr;
    logic [33:0]   o_seq, e_seq;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      s = DW'(i);
      model_tick(s, 0, 0, e_echo, e_rd, e_wr);
      do_tick(s, 0, '0, o_echo, o_seq);
      e_seq = {e_rd, e_wr, 2'b10, s, 7'b0000100, 7'b0000011};
      n_tests += 2;
      if (o_seq !== e_seq) begin
        n_fail++; $display("FAIL basic_seq tick %0d: got %h want %h", i, o_seq, e_seq);
      end
      if (o_echo !== e_echo) begin
        n_fail++; $display("FAIL basic_echo tick %0d: got %h want %h", i, o_echo, e_echo);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] s, e_echo, o_echo;
    logic [AW-1:0] e_rd, e_wr;
    logic [33:0]   o_seq, e_seq;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      s = DW'($urandom_range(0, 1023));
      model_tick(s, 0, 0, e_echo, e_rd, e_wr);
      do_tick(s, 0, '0, o_echo, o_seq);
      e_seq = {e_rd, e_wr, 2'b10, s, 7'b0000100, 7'b0000011};
      n_tests += 2;
      if (o_seq !== e_seq) begin
        n_fail++; $display("FAIL wrap_seq tick %0d: got %h want %h", i, o_seq, e_seq);
      end
      if (o_echo !== e_echo) begin
        n_fail++; $display("FAIL wrap_echo tick %0d: got %h want %h", i, o_echo, e_echo);
      end
    end
  endtask

  task automatic test_delay_change();
    logic [DW-1:0] s, e_echo, o_echo;
    logic [AW-1:0] e_rd, e_wr, len;
    logic [33:0]   o_seq, e_seq;
    bit            ld;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      s   = DW'($urandom_range(0, 1023));
      ld  = 1'b0;
      len = '0;
      if (i == 6) pulse_load(AW'(5));
      if (i == 20) begin ld = 1'b1; len = AW'(2); end
      if (i >= 30) begin
        ld  = ($urandom_range(0, 4) == 0);
        len = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) pulse_load(AW'($urandom_range(0, 15)));
      end
      model_tick(s, ld, int'(len), e_echo, e_rd, e_wr);
      do_tick(s, ld, len, o_echo, o_seq);
      e_seq = {e_rd, e_wr, 2'b10, s, 7'b0000100, 7'b0000011};
      n_tests += 2;
      if (o_seq !== e_seq) begin
        n_fail++; $display("FAIL delay_seq tick %0d: got %h want %h", i, o_seq, e_seq);
      end
      if (o_echo !== e_echo) begin
        n_fail++; $display("FAIL delay_echo tick %0d: got %h want %h", i, o_echo, e_echo);
      end
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] s, e_echo, o_echo, s1, s2, e1, e2;
    logic [AW-1:0] e_rd, e_wr, r2, w2;
    logic [33:0]   o_seq;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = DW'($urandom_range(0, 1023));
      model_tick(s, 0, 0, e_echo, e_rd, e_wr);
      do_tick(s, 0, '0, o_echo, o_seq);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_initial: got %b want 0", overrun);
    end
    s1 = DW'($urandom_range(0, 1023));
    s2 = DW'($urandom_range(0, 1023));
    model_tick(s1, 0, 0, e1, e_rd, e_wr);
    @(posedge clk); #1; tick = 1'b1; sample_in = s1;
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1; tick = 1'b1; sample_in = ~s1;
    @(posedge clk); #1;
    n_tests += 2;
    if ({echo_valid, echo_out} !== {1'b1, e1}) begin
      n_fail++; $display("FAIL overrun_first_echo: got %b/%h want 1/%h", echo_valid, echo_out, e1);
    end
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    tick = 1'b1; sample_in = s2;
    model_tick(s2, 0, 0, e2, r2, w2);
    @(posedge clk); #1; tick = 1'b0;
    n_tests++;
    if ({busy, ram_if.we, ram_if.addr} !== {1'b1, 1'b0, r2}) begin
      n_fail++;
      $display("FAIL overrun_next_rd: got busy=%b we=%b addr=%h want 1/0/%h",
               busy, ram_if.we, ram_if.addr, r2);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({ram_if.we, ram_if.addr, ram_if.wdata} !== {1'b1, w2, s2}) begin
      n_fail++;
      $display("FAIL overrun_next_wr: got we=%b addr=%h data=%h want 1/%h/%h",
               ram_if.we, ram_if.addr, ram_if.wdata, w2, s2);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({echo_valid, echo_out} !== {1'b1, e2}) begin
      n_fail++; $display("FAIL overrun_next_echo: got %b/%h want 1/%h", echo_valid, echo_out, e2);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] s, e_echo, o_echo;
    logic [AW-1:0] e_rd, e_wr;
    logic [33:0]   o_seq, e_seq;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s = DW'($urandom_range(0, 1023));
      model_tick(s, 0, 0, e_echo, e_rd, e_wr);
      do_tick(s, 0, '0, o_echo, o_seq);
    end
    pulse_load(AW'(7));
    @(posedge clk); #1; tick = 1'b1; sample_in = DW'($urandom_range(0, 1023));
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (ram_if.we !== 1'b1) begin
      n_fail++; $display("FAIL midop_in_wr: got we=%b want 1", ram_if.we);
    end
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({ram_if.we, busy, echo_valid, echo_out, overrun} !== '0) begin
        n_fail++;
        $display("FAIL midop_reset cyc %0d: got we=%b busy=%b vld=%b echo=%h ovr=%b want all 0",
                 j, ram_if.we, busy, echo_valid, echo_out, overrun);
      end
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      s = DW'($urandom_range(0, 1023));
      model_tick(s, 0, 0, e_echo, e_rd, e_wr);
      do_tick(s, 0, '0, o_echo, o_seq);
      e_seq = {e_rd, e_wr, 2'b10, s, 7'b0000100, 7'b0000011};
      n_tests += 2;
      if (o_seq !== e_seq) begin
        n_fail++; $display("FAIL midop_seq tick %0d: got %h want %h", i, o_seq, e_seq);
      end
      if (o_echo !== e_echo) begin
        n_fail++; $display("FAIL midop_echo tick %0d: got %h want %h", i, o_echo, e_echo);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_echo();
    test_wrap();
    test_delay_change();
    test_overrun();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
